// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART transmit-side definitions: FSM encodings and default timing constants.
// The receive side reuses the timing defaults.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 4096;
    localparam int DEF_GAP_CYC     = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART transmit arbiter.
// master = arbiter view, slave = requesters/transmitter view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_enable;
    logic                      char_sent;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        input  req, req_data, char_sent,
        output grant, done, tx_data, tx_enable, busy, timeout_err
    );

    modport slave (
        output req, req_data, char_sent,
        input  grant, done, tx_data, tx_enable, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request scanning upward from last+1 with wrap.
// Zero latency; no state.
module uart_tx_arbiter_rr #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        // Walk from the farthest offset down so the nearest pending request wins.
        for (int off = NUM_REQ; off >= 1; off--) begin
            int j;
            j = (int'(last) + off) % NUM_REQ;
            if (req[j]) begin
                win_oh    = '0;
                win_oh[j] = 1'b1;
                win_idx   = IDX_W'(j);
                win_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: round-robin grant 1 cycle after req in IDLE,
// holds the byte until char_sent or timeout, then enforces an idle gap; requests outside IDLE wait.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC
) (
    input  logic              clk9600x16,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [NUM_REQ-1:0]  grant_q, grant_nxt;
    logic [NUM_REQ-1:0]  done_q, done_nxt;
    logic [NUM_REQ-1:0]  win_q, win_nxt;
    logic [IDX_W-1:0]    last_q, last_nxt;
    logic [DATA_W-1:0]   tx_data_q, tx_data_nxt;
    logic                tx_en_q, tx_en_nxt;
    logic                terr_q, terr_nxt;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;

    uart_tx_arbiter_rr #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (bus.req),
        .last    (last_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    always_ff @(posedge clk9600x16 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            win_q     <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            grant_q   <= grant_nxt;
            done_q    <= done_nxt;
            win_q     <= win_nxt;
            last_q    <= last_nxt;
            tx_data_q <= tx_data_nxt;
            tx_en_q   <= tx_en_nxt;
            terr_q    <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        grant_nxt   = '0;
        done_nxt    = '0;
        win_nxt     = win_q;
        last_nxt    = last_q;
        tx_data_nxt = tx_data_q;
        tx_en_nxt   = tx_en_q;
        terr_nxt    = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    tx_data_nxt = bus.req_data[pick_idx*DATA_W +: DATA_W];
                    grant_nxt   = pick_oh;
                    win_nxt     = pick_oh;
                    last_nxt    = pick_idx;
                    cnt_nxt     = '0;
                    tx_en_nxt   = 1'b1;
                    state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_nxt = cnt_q + CNT_W'(1);
                // char_sent takes priority over a coincident timeout.
                if (bus.char_sent) begin
                    done_nxt  = win_q;
                    tx_en_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tx_en_nxt = 1'b0;
                    terr_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q < CNT_W'(GAP_CYC)) cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q >= CNT_W'(GAP_CYC - 1) && !bus.char_sent) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_enable   = tx_en_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transmitter behaviour is played by the stimulus sequence.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(4096), .GAP_CYC(16)) dut (
        .clk9600x16 (clk),
        .rst        (rst),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Waits for a grant, plays a transmitter that raises char_sent in the len-th SEND cycle and holds it hold cycles.
    task automatic serve(input string tag, input int idx, input logic [7:0] dat,
                         input int len, input int hold, output int gt, output int lat);
        logic en_ok;
        logic extra;
        lat = 0;
        while (bus.grant === 4'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        gt = cyc;
        check({tag, " grant"}, 32'(bus.grant), 32'(4'b1 << idx));
        check({tag, " tx_data"}, 32'(bus.tx_data), 32'(dat));
        en_ok = 1'b1;
        for (int k = 0; k < len; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (bus.grant !== 4'b0) en_ok = 1'b0;
            end
            if (bus.tx_enable !== 1'b1 || bus.done !== 4'b0 || bus.tx_data !== dat) en_ok = 1'b0;
            if (k == len - 1) bus.char_sent = 1'b1;
        end
        check({tag, " send window"}, 32'(en_ok), 32'd1);
        extra = 1'b0;
        for (int g = 0; g < hold; g++) begin
            @(negedge clk);
            if (g == 0) begin
                check({tag, " done"}, 32'(bus.done), 32'(4'b1 << idx));
                check({tag, " tx_enable off"}, 32'(bus.tx_enable), 32'd0);
            end else if (bus.done !== 4'b0) begin
                extra = 1'b1;
            end
            if (g == hold - 1) bus.char_sent = 1'b0;
        end
        check({tag, " single done"}, 32'(extra), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int w;
        logic spurious;
        w = 0;
        spurious = 1'b0;
        while (bus.busy !== 1'b0 && w < 200) begin
            @(negedge clk);
            if (bus.done !== 4'b0 || bus.grant !== 4'b0) spurious = 1'b1;
            w++;
        end
        check({tag, " idle"}, 32'(bus.busy), 32'd0);
        check({tag, " quiet gap"}, 32'(spurious), 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int g0, g1, g2, lat, cnt;
        logic seen;
        rst = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.char_sent = 1'b0;
        repeat (2) @(negedge clk);
        check("rst grant", 32'(bus.grant), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst tx_enable", 32'(bus.tx_enable), 32'd0);
        check("rst tx_data", 32'(bus.tx_data), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;

        // 1: single byte, 160-cycle character
        @(negedge clk);
        bus.req = 4'b0100;
        bus.req_data = 32'h0041_0000;
        serve("t1", 2, 8'h41, 160, 1, g0, lat);
        check("t1 grant latency", 32'(lat), 32'd1);
        bus.req = '0;
        repeat (15) @(negedge clk);
        check("t1 busy in gap", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("t1 busy after gap", 32'(bus.busy), 32'd0);

        // 2: all four requesting, round-robin from reset
        pulse_rst();
        bus.req = 4'b1111;
        bus.req_data = 32'h1312_1110;
        serve("t2a", 0, 8'h10, 20, 1, g0, lat);
        serve("t2b", 1, 8'h11, 20, 1, g1, lat);
        check("t2 spacing", 32'(g1 - g0), 32'd37);
        serve("t2c", 2, 8'h12, 20, 1, g0, lat);
        serve("t2d", 3, 8'h13, 20, 1, g0, lat);
        serve("t2e", 0, 8'h10, 20, 1, g0, lat);
        bus.req = '0;
        wait_idle("t2");

        // 3: two requesters alternate
        pulse_rst();
        bus.req = 4'b0011;
        bus.req_data = 32'h0000_B1A0;
        serve("t3a", 0, 8'hA0, 12, 1, g0, lat);
        serve("t3b", 1, 8'hB1, 12, 1, g0, lat);
        serve("t3c", 0, 8'hA0, 12, 1, g0, lat);
        serve("t3d", 1, 8'hB1, 12, 1, g0, lat);
        bus.req = '0;
        wait_idle("t3");

        // 4: hung transmitter, then normal service with sticky error
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_2200;
        lat = 0;
        while (bus.grant === 4'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("t4 grant", 32'(bus.grant), 32'b0010);
        cnt = 0;
        seen = 1'b0;
        while (bus.tx_enable === 1'b1 && cnt < 5000) begin
            if (bus.done !== 4'b0) seen = 1'b1;
            @(negedge clk);
            cnt++;
        end
        check("t4 send cycles", 32'(cnt), 32'd4096);
        check("t4 no done", 32'(seen | (|bus.done)), 32'd0);
        check("t4 timeout_err", 32'(bus.timeout_err), 32'd1);
        bus.req = '0;
        wait_idle("t4");
        bus.req = 4'b1000;
        bus.req_data = 32'h3300_0000;
        serve("t4b", 3, 8'h33, 16, 1, g0, lat);
        check("t4 err sticky", 32'(bus.timeout_err), 32'd1);
        bus.req = '0;
        wait_idle("t4b");

        // 5: char_sent held high, single requester streaming
        bus.req = 4'b0001;
        bus.req_data = 32'h0000_0055;
        serve("t5a", 0, 8'h55, 30, 5, g0, lat);
        serve("t5b", 0, 8'h55, 30, 20, g1, lat);
        check("t5 spacing hold5", 32'(g1 - g0), 32'd47);
        serve("t5c", 0, 8'h55, 30, 1, g2, lat);
        check("t5 spacing hold20", 32'(g2 - g1), 32'd51);
        bus.req = '0;
        wait_idle("t5");

        // 6: reset in the middle of a send
        bus.req = 4'b1000;
        bus.req_data = 32'h7700_0000;
        lat = 0;
        while (bus.grant === 4'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("t6 grant", 32'(bus.grant), 32'b1000);
        repeat (3) @(negedge clk);
        check("t6 sending", 32'(bus.tx_enable), 32'd1);
        rst = 1'b1;
        #1;
        check("t6 tx_enable async", 32'(bus.tx_enable), 32'd0);
        check("t6 busy", 32'(bus.busy), 32'd0);
        check("t6 done", 32'(bus.done), 32'd0);
        check("t6 timeout_err", 32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1001;
        bus.req_data = 32'h7700_0099;
        serve("t6b", 0, 8'h99, 10, 1, g0, lat);
        bus.req = '0;
        wait_idle("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
